sl_preceptron_mac_lanes: RTL and testbench

- Parametrised successor to the single-lane perceptron MAC.
- Consumes DATA_IN_LANES signed inputs per beat over a valid/ready stream and fetches one wide weight word per beat from weight memory.
- Multiplies lane-wise, reduces with an adder tree, and accumulates onto a latched bias. The vector length is counted internally rather than signalled by a done strobe.
- Presents sum and threshold-compare result through a valid/ready result port. Sits between the input stream fabric and the status/config register block.

---
 rtl/sl_preceptron_mac_lanes_pkg.sv | 27 ++
 rtl/sl_preceptron_mac_lanes_adder_tree.sv | 30 +++
 rtl/sl_preceptron_mac_lanes.sv | 171 +++++++++++++++++
 tb/tb_sl_preceptron_mac_lanes.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sl_preceptron_mac_lanes_pkg.sv
// Shared types and width helpers for the multi-lane perceptron MAC.
// Default-configuration derived widths live here; the top recomputes them from its parameters.
package sl_preceptron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_LANES   = 4;
    localparam int DEF_DIN_W   = 8;
    localparam int DEF_WGT_W   = 8;
    localparam int PROD_WIDTH  = DEF_DIN_W + DEF_WGT_W;
    localparam int TREE_WIDTH  = PROD_WIDTH + clog2(DEF_LANES);

endpackage

// File: rtl/sl_preceptron_mac_lanes_adder_tree.sv
// Signed pairwise reduction of LANES packed products into one tree-width sum.
// Latency: combinational. Backpressure: none, pure datapath.
// LANES must be a power of two; the in-place halving pass relies on it.
module sl_mac_adder_tree
    import sl_preceptron_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int PROD_W = PROD_WIDTH,
    parameter int TREE_W = TREE_WIDTH
) (
    input  logic [LANES*PROD_W-1:0] prods,
    output logic signed [TREE_W-1:0] sum
);

    logic signed [TREE_W-1:0] node [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            node[i] = TREE_W'($signed(prods[i*PROD_W +: PROD_W]));
        end
        // Each pass halves the live width; entries 2j/2j+1 are never overwritten before use.
        for (int w = LANES / 2; w >= 1; w = w / 2) begin
            for (int j = 0; j < w; j++) begin
                node[j] = node[2*j] + node[2*j+1];
            end
        end
        sum = node[0];
    end

endmodule

// File: rtl/sl_preceptron_mac_lanes.sv
// Multi-lane perceptron MAC: lane products, adder tree, accumulate onto bias, threshold compare.
// Latency: result valid 3 cycles after the last beat is accepted. Backpressure: in_ready only in RUN,
// result held until res_ready. Optional clamp-on-accumulate with sticky res_sat under SL_MAC_SATURATE_EN.
module sl_preceptron_mac_lanes
    import sl_preceptron_pkg::*;
#(
    parameter int DATA_IN_LANES  = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int WEIGHTS_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int BEAT_CNT_WIDTH = 16,
    parameter int SUM_WIDTH      = 24
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [BEAT_CNT_WIDTH-1:0]               cfg_vec_beats,
    input  logic [MEM_ADDR_WIDTH-1:0]               cfg_base_addr,
    input  logic [SUM_WIDTH-1:0]                    cfg_bias,
    input  logic [SUM_WIDTH-1:0]                    cfg_threshold,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0]  in_data,
    output logic                                    mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0]               mem_addr,
    input  logic [DATA_IN_LANES*WEIGHTS_WIDTH-1:0]  mem_rdata,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [SUM_WIDTH-1:0]                    res_sum,
    output logic                                    res_fire,
`ifdef SL_MAC_SATURATE_EN
    output logic                                    res_sat,
`endif
    output logic                                    busy
);

    localparam int PW = DATA_IN_WIDTH + WEIGHTS_WIDTH;
    localparam int TW = PW + clog2(DATA_IN_LANES);

    state_t                                 state;
    logic [BEAT_CNT_WIDTH-1:0]              vec_beats_q;
    logic [BEAT_CNT_WIDTH-1:0]              beat_cnt;
    logic [MEM_ADDR_WIDTH-1:0]              base_q;
    logic [MEM_ADDR_WIDTH-1:0]              addr_q;
    logic signed [SUM_WIDTH-1:0]            thr_q;
    logic signed [SUM_WIDTH-1:0]            acc;
    logic signed [SUM_WIDTH-1:0]            acc_next;
    logic                                   s1_vld;
    logic                                   s2_vld;
    logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] s1_dat;
    logic [DATA_IN_LANES*PW-1:0]            prod_dat;
    logic [DATA_IN_LANES*PW-1:0]            s2_prod;
    logic signed [TW-1:0]                   tree_sum;
    logic                                   accept;
    logic                                   last_beat;

    assign in_ready  = (state == RUN);
    assign busy      = (state != IDLE);
    assign res_valid = (state == RESULT);
    assign res_sum   = acc;
    assign accept    = in_valid & in_ready;
    assign mem_ren   = accept;
    assign mem_addr  = accept ? base_q + MEM_ADDR_WIDTH'(beat_cnt) : addr_q;
    assign last_beat = (beat_cnt == vec_beats_q - BEAT_CNT_WIDTH'(1));

    // mem_rdata lines up with stage 1 because the read was issued on the accept cycle.
    always_comb begin
        prod_dat = '0;
        for (int i = 0; i < DATA_IN_LANES; i++) begin
            prod_dat[i*PW +: PW] = PW'($signed(s1_dat[i*DATA_IN_WIDTH +: DATA_IN_WIDTH]) *
                                       $signed(mem_rdata[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]));
        end
    end

    sl_mac_adder_tree #(
        .LANES  (DATA_IN_LANES),
        .PROD_W (PW),
        .TREE_W (TW)
    ) u_tree (
        .prods (s2_prod),
        .sum   (tree_sum)
    );

`ifdef SL_MAC_SATURATE_EN
    logic signed [SUM_WIDTH:0] acc_wide;
    logic                      sat_hit;

    always_comb begin
        acc_wide = (SUM_WIDTH+1)'(acc) + (SUM_WIDTH+1)'(tree_sum);
        sat_hit  = (acc_wide[SUM_WIDTH] != acc_wide[SUM_WIDTH-1]);
        if (!sat_hit)
            acc_next = acc_wide[SUM_WIDTH-1:0];
        else if (acc_wide[SUM_WIDTH])
            acc_next = {1'b1, {(SUM_WIDTH-1){1'b0}}};
        else
            acc_next = {1'b0, {(SUM_WIDTH-1){1'b1}}};
    end
`else
    always_comb begin
        acc_next = acc + SUM_WIDTH'(tree_sum);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vec_beats_q <= '0;
            beat_cnt    <= '0;
            base_q      <= '0;
            addr_q      <= '0;
            thr_q       <= '0;
            acc         <= '0;
            s1_vld      <= 1'b0;
            s2_vld      <= 1'b0;
            s1_dat      <= '0;
            s2_prod     <= '0;
            res_fire    <= 1'b0;
`ifdef SL_MAC_SATURATE_EN
            res_sat     <= 1'b0;
`endif
        end else begin
            s1_vld <= accept;
            s2_vld <= s1_vld;
            if (accept) begin
                s1_dat   <= in_data;
                addr_q   <= mem_addr;
                beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
            end
            if (s1_vld) s2_prod <= prod_dat;
            if (s2_vld) acc <= acc_next;
`ifdef SL_MAC_SATURATE_EN
            if (s2_vld && sat_hit) res_sat <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_beats_q <= cfg_vec_beats;
                        base_q      <= cfg_base_addr;
                        thr_q       <= cfg_threshold;
                        acc         <= cfg_bias;
                        beat_cnt    <= '0;
`ifdef SL_MAC_SATURATE_EN
                        res_sat     <= 1'b0;
`endif
                        if (cfg_vec_beats != '0) begin
                            state <= RUN;
                        end else begin
                            state    <= RESULT;
                            res_fire <= ($signed(cfg_bias) > $signed(cfg_threshold));
                        end
                    end
                end
                RUN: begin
                    if (accept && last_beat) state <= DRAIN;
                end
                DRAIN: begin
                    // Stage 2 retires on this same edge, so compare against the value it produces.
                    if (!s1_vld) begin
                        state    <= RESULT;
                        res_fire <= ((s2_vld ? acc_next : acc) > thr_q);
                    end
                end
                RESULT: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sl_preceptron_mac_lanes.sv
// Directed bench for sl_preceptron_mac_lanes (4 lanes, 18-bit accumulator) with a registered weight memory model.
module tb_sl_preceptron_mac_lanes;

    localparam int SW = 18;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   cfg_vec_beats;
    logic [15:0]   cfg_base_addr;
    logic [SW-1:0] cfg_bias;
    logic [SW-1:0] cfg_threshold;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          mem_ren;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_rdata;
    logic          res_valid;
    logic          res_ready;
    logic [SW-1:0] res_sum;
    logic          res_fire;
    logic          busy;
`ifdef SL_MAC_SATURATE_EN
    logic          res_sat;
`endif

    int tests_run;
    int tests_failed;
    logic [31:0] wmem [256];

    sl_preceptron_mac_lanes #(
        .DATA_IN_LANES  (4),
        .DATA_IN_WIDTH  (8),
        .WEIGHTS_WIDTH  (8),
        .MEM_ADDR_WIDTH (16),
        .BEAT_CNT_WIDTH (16),
        .SUM_WIDTH      (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_vec_beats (cfg_vec_beats),
        .cfg_base_addr (cfg_base_addr),
        .cfg_bias      (cfg_bias),
        .cfg_threshold (cfg_threshold),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .mem_ren       (mem_ren),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_sum       (res_sum),
        .res_fire      (res_fire),
`ifdef SL_MAC_SATURATE_EN
        .res_sat       (res_sat),
`endif
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= wmem[mem_addr[7:0]];
    end

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int beats, input int base, input int bias, input int thr);
        cfg_vec_beats = 16'(beats);
        cfg_base_addr = 16'(base);
        cfg_bias      = SW'(bias);
        cfg_threshold = SW'(thr);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_handshake: busy=%b res_valid=%b, required 0 0", name, busy, res_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({in_ready, mem_ren, res_valid, res_fire, busy} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: in_ready/mem_ren/res_valid/res_fire/busy=%b, required 00000",
                     {in_ready, mem_ren, res_valid, res_fire, busy});
        end
        tests_run++;
        if (mem_addr !== 16'h0 || res_sum !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: mem_addr=%h res_sum=%h, required 0 0", mem_addr, res_sum);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        wmem[8'h10] = pack4(2, 2, 2, 2);
        wmem[8'h11] = pack4(2, 2, 2, 2);
        do_start(2, 'h10, 0, 70);
        in_valid = 1'b1;
        in_data  = pack4(1, 2, 3, 4);
        #1;
        tests_run++;
        if (mem_ren !== 1'b1 || mem_addr !== 16'h0010) begin
            tests_failed++;
            $display("FAIL basic_addr0: mem_ren=%b mem_addr=%h, required 1 0010", mem_ren, mem_addr);
        end
        tick();
        in_data = pack4(5, 6, 7, 8);
        #1;
        tests_run++;
        if (mem_ren !== 1'b1 || mem_addr !== 16'h0011) begin
            tests_failed++;
            $display("FAIL basic_addr1: mem_ren=%b mem_addr=%h, required 1 0011", mem_ren, mem_addr);
        end
        tick();
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || mem_ren !== 1'b0 || mem_addr !== 16'h0011 || res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_drain1: in_ready=%b mem_ren=%b mem_addr=%h res_valid=%b, required 0 0 0011 0",
                     in_ready, mem_ren, mem_addr, res_valid);
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_early_valid: res_valid=%b at T+2, required 0", res_valid);
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_sum !== SW'(72) || res_fire !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_result: valid=%b sum=%0d fire=%b, required 1 72 1",
                     res_valid, $signed(res_sum), res_fire);
        end
        handshake("basic");
    endtask

    task automatic test_signed();
        wmem[8'h20] = pack4(127, -128, -1, 5);
        do_start(1, 'h20, 10, 0);
        in_valid = 1'b1;
        in_data  = pack4(-128, 127, -1, 0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_sum !== SW'(-32501) || res_fire !== 1'b0) begin
            tests_failed++;
            $display("FAIL signed_result: valid=%b sum=%0d fire=%b, required 1 -32501 0",
                     res_valid, $signed(res_sum), res_fire);
        end
        handshake("signed");
    endtask

    task automatic test_zero_beats();
        in_valid = 1'b1;
        in_data  = pack4(9, 9, 9, 9);
        do_start(0, 'h30, -5, -6);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (res_valid !== 1'b1 || res_sum !== SW'(-5) || res_fire !== 1'b1 || mem_ren !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_beats_%0d: valid=%b sum=%0d fire=%b mem_ren=%b, required 1 -5 1 0",
                         k, res_valid, $signed(res_sum), res_fire, mem_ren);
            end
            tick();
        end
        in_valid = 1'b0;
        handshake("zero_beats");
    endtask

    task automatic test_bubbles();
        logic [31:0] bd [3];
        logic [15:0] ea [3];
        wmem[8'hFF] = pack4(1, 1, 1, 1);
        wmem[8'h00] = pack4(2, 2, 2, 2);
        wmem[8'h01] = pack4(-1, -1, -1, -1);
        bd[0] = pack4(1, 2, 3, 4);
        bd[1] = pack4(1, 1, 1, 1);
        bd[2] = pack4(3, 3, 3, 3);
        ea[0] = 16'hFFFF;
        ea[1] = 16'h0000;
        ea[2] = 16'h0001;
        do_start(3, 'hFFFF, 100, 106);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = bd[b];
            #1;
            tests_run++;
            if (mem_ren !== 1'b1 || mem_addr !== ea[b]) begin
                tests_failed++;
                $display("FAIL bubble_addr%0d: mem_ren=%b mem_addr=%h, required 1 %h", b, mem_ren, mem_addr, ea[b]);
            end
            tick();
            in_valid = 1'b0;
            in_data  = pack4(100, 100, 100, 100);
            #1;
            tests_run++;
            if (mem_ren !== 1'b0 || mem_addr !== ea[b]) begin
                tests_failed++;
                $display("FAIL bubble_hold%0d: mem_ren=%b mem_addr=%h, required 0 %h", b, mem_ren, mem_addr, ea[b]);
            end
            if (b < 2) tick();
        end
        tick();
        tests_run++;
        if (res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_early_valid: res_valid=%b at T+2, required 0", res_valid);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (res_valid !== 1'b1 || res_sum !== SW'(106) || res_fire !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bubble_hold_result%0d: valid=%b sum=%0d fire=%b busy=%b, required 1 106 0 1",
                         k, res_valid, $signed(res_sum), res_fire, busy);
            end
            if (k == 1) begin
                cfg_vec_beats = 16'd5;
                cfg_bias      = '0;
                start         = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        tests_run++;
        if (in_ready !== 1'b0 || res_sum !== SW'(106)) begin
            tests_failed++;
            $display("FAIL bubble_start_ignored: in_ready=%b sum=%0d, required 0 106", in_ready, $signed(res_sum));
        end
        handshake("bubble");
    endtask

    task automatic test_saturate();
        for (int a = 'h40; a < 'h44; a++) wmem[a] = pack4(127, 127, 127, 127);
        do_start(4, 'h40, 0, 0);
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1;
            in_data  = pack4(127, 127, 127, 127);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
`ifdef SL_MAC_SATURATE_EN
        tests_run++;
        if (res_valid !== 1'b1 || res_sum !== SW'(131071) || res_fire !== 1'b1 || res_sat !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturate_result: valid=%b sum=%0d fire=%b sat=%b, required 1 131071 1 1",
                     res_valid, $signed(res_sum), res_fire, res_sat);
        end
`else
        tests_run++;
        if (res_valid !== 1'b1 || res_sum !== SW'(-4080) || res_fire !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_result: valid=%b sum=%0d fire=%b, required 1 -4080 0",
                     res_valid, $signed(res_sum), res_fire);
        end
`endif
        handshake("saturate");
    endtask

    task automatic test_abort();
        for (int a = 'h50; a < 'h58; a++) wmem[a] = pack4(1, 1, 1, 1);
        wmem[8'h60] = pack4(3, 3, 3, 3);
        do_start(8, 'h50, 0, 0);
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_data  = pack4(5, 5, 5, 5);
            tick();
        end
        in_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, mem_ren, res_valid, res_fire, busy} !== 5'b0 || mem_addr !== 16'h0 || res_sum !== '0) begin
            tests_failed++;
            $display("FAIL abort_reset: flags=%b mem_addr=%h sum=%h, required 00000 0 0",
                     {in_ready, mem_ren, res_valid, res_fire, busy}, mem_addr, res_sum);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        do_start(1, 'h60, 7, 0);
        in_valid = 1'b1;
        in_data  = pack4(1, 1, 1, 1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (res_valid !== 1'b1 || res_sum !== SW'(19) || res_fire !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_fresh: valid=%b sum=%0d fire=%b, required 1 19 1",
                     res_valid, $signed(res_sum), res_fire);
        end
`ifdef SL_MAC_SATURATE_EN
        tests_run++;
        if (res_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_sat_clear: res_sat=%b, required 0", res_sat);
        end
`endif
        handshake("abort");
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst           = 1'b1;
        start         = 1'b0;
        cfg_vec_beats = '0;
        cfg_base_addr = '0;
        cfg_bias      = '0;
        cfg_threshold = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        res_ready     = 1'b0;
        mem_rdata     = '0;
        for (int i = 0; i < 256; i++) wmem[i] = '0;

        test_reset();
        test_basic();
        test_signed();
        test_zero_beats();
        test_bubbles();
        test_saturate();
        test_abort();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
